reduce_scheduler: RTL and testbench
===================================

Name: reduce_scheduler

Overview:
- Round-robin scheduler that shares one reduce_vector_alu instance between NREQ requesters.
- Accepts per-requester reduce jobs (op select, length) and steers the ALU's vector source mux to the granted requester.
- Sequences the ALU's set/run/done protocol and returns the tagged result over a valid/ready response channel.
- Sits between the command decoder / HAL register front-end and the reduce datapath.

Parameters:
- BITS, 8, data and length width; matches the ALU.
- N, 64, maximum vector length of the ALU.
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, N+8, cycles to wait in RUN for alu_done before aborting with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NREQ  per-requester job request; held high until the response is accepted.
- req_sel  in  NREQ x 2  per-requester op: 00 sum, 01 or, 10 min, 11 max.
- req_len  in  NREQ x BITS  per-requester element count.
- gnt  out  NREQ  one-hot grant; high from acceptance through response handshake.
- alu_src  out  $clog2(NREQ)  vector-source mux select (granted id).
- alu_set  out  1  one-cycle load/start pulse to the ALU.
- alu_en  out  1  ALU output enable.
- alu_sel  out  2  registered op for the ALU.
- alu_len  out  BITS  registered, clamped length for the ALU.
- alu_done  in  1  ALU result valid.
- alu_out  in  BITS  ALU result (signed).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  $clog2(NREQ)  requester id of the response.
- resp_data  out  BITS  captured result.
- resp_err  out  1  1 = timeout abort; resp_data is 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Reset applies mid-operation: the job is dropped, no response is issued, and alu_set is not pulsed.
- IDLE:
  - If any req bit is high, pick the first set bit searching upward from pointer+1 (wrapping).
  - Register gnt, alu_src, alu_sel and alu_len; go to SET.
  - alu_len = min(req_len, N).
- SET (1 cycle):
  - alu_set=1; timeout counter cleared; go to RUN.
  - alu_done is ignored in this cycle: a stale done from the previous job is cleared by the ALU at this edge.
- RUN:
  - alu_en=1; counter increments each cycle.
  - On alu_done=1: capture alu_out into resp_data, resp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: resp_data=0, resp_err=1, go to RESP.
- RESP:
  - resp_valid=1, alu_en=0; resp_* and gnt held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: gnt cleared, pointer = granted id, go to IDLE.
  - No back-to-back bypass, so one idle cycle separates jobs.
- Latency: resp_valid rises exactly alu_len+4 cycles after the IDLE cycle that accepted the request (clamped length, nominal ALU).
- Changes to req, req_sel or req_len during a job are ignored; the registered copies are used.
- A requester dropping req mid-job still receives its response.
- Fairness: a requester that keeps req high cannot be re-granted while another requester is waiting.
- Zero length: the ALU completes with its identity values (sum 0, or 0, min = max-positive, max = max-negative); the value is forwarded unmodified.

Decomposition:
- reduce_pkg holds:
  - typedef enum {IDLE, SET, RUN, RESP} reduce_sched_state_t
  - reduce_op_t (2-bit op codes SUM, OR, MIN, MAX)
  - localparam ID_W = $clog2(NREQ)
- Sub-module rr_arbiter (req, pointer -> one-hot grant plus id), reusable by future shared-resource blocks.
- The FSM, clamp, timeout counter and response register live in reduce_scheduler.

Test Plan:
- Single job: req[0]=1, sel=00, len=4, vector {1,2,3,4}.
  - resp_valid at cycle 8, resp_id=0, resp_data=10, resp_err=0.
  - alu_set high exactly one cycle.
- Round robin: req=4'b1111 held, all len=2.
  - Grant order 0,1,2,3,0.
  - Each resp_id matches its grant; op results correct for max (vector {-3,5} -> 5) and min (-> -3).
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - resp_data, resp_id and gnt stable; no new grant while req[1] is pending.
  - Grant to 1 issued one cycle after the handshake.
- Clamp and zero length:
  - len=200, N=64 -> alu_len=64, response at cycle 68.
  - len=0 with sel=00 -> resp_data=0 at cycle 4.
- Timeout: ALU model never asserts done.
  - resp_valid with resp_err=1, resp_data=0 after TIMEOUT cycles in RUN; returns to IDLE after handshake.
- Reset mid-RUN: rst_n=0 for one cycle during a len=30 job.
  - All outputs 0 next cycle; no response for the dropped job.
  - Requester 0 granted first afterwards.

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared types and helpers for the reduce scheduler and its arbiter.
package reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } reduce_sched_state_t;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_OR  = 2'b01,
    OP_MIN = 2'b10,
    OP_MAX = 2'b11
  } reduce_op_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int ID_W = $clog2(NREQ_DEFAULT);

  // Limit a requested element count to what the ALU can process.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);

  logic [IDW:0] cand;
  logic         found;

  // Search upward from ptr+1; the last slot visited is ptr itself.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IDW-1:0]]   = 1'b1;
        id                   = cand[IDW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reduce_scheduler.sv
// Shares one reduce ALU between NREQ requesters and returns tagged results.
//
// state | meaning
// IDLE  | waiting for any req; arbitrate and latch the winner's job
// SET   | one-cycle alu_set pulse; timeout counter cleared
// RUN   | alu_en high; wait for alu_done or timeout
// RESP  | resp_valid held until resp_ready; then release grant
module reduce_scheduler
  import reduce_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int N       = 64,
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = N + 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][1:0]       req_sel,
  input  logic [NREQ-1:0][BITS-1:0]  req_len,
  output logic [NREQ-1:0]            gnt,
  output logic [$clog2(NREQ)-1:0]    alu_src,
  output logic                       alu_set,
  output logic                       alu_en,
  output logic [1:0]                 alu_sel,
  output logic [BITS-1:0]            alu_len,
  input  logic                       alu_done,
  input  logic [BITS-1:0]            alu_out,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NREQ)-1:0]    resp_id,
  output logic [BITS-1:0]            resp_data,
  output logic                       resp_err,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  reduce_sched_state_t state;
  logic [IDW-1:0]      ptr;
  logic [CW-1:0]       tmo_cnt;
  logic [NREQ-1:0]     arb_gnt;
  logic [IDW-1:0]      arb_id;
  logic                arb_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (req),
    .ptr  (ptr),
    .gnt  (arb_gnt),
    .id   (arb_id),
    .any  (arb_any)
  );

  assign busy = (state != IDLE);

  // Job sequencing: arbitrate, pulse set, run with timeout, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      tmo_cnt    <= '0;
      gnt        <= '0;
      alu_src    <= '0;
      alu_set    <= 1'b0;
      alu_en     <= 1'b0;
      alu_sel    <= '0;
      alu_len    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      alu_set <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt     <= arb_gnt;
            alu_src <= arb_id;
            alu_sel <= req_sel[arb_id];
            alu_len <= BITS'(clamp_len(int'(req_len[arb_id]), N));
            alu_set <= 1'b1;
            state   <= SET;
          end
        end
        SET: begin
          // alu_done may still be high from the previous job here; ignore it.
          tmo_cnt <= '0;
          alu_en  <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (alu_done) begin
            resp_data  <= alu_out;
            resp_err   <= 1'b0;
            resp_id    <= alu_src;
            resp_valid <= 1'b1;
            alu_en     <= 1'b0;
            state      <= RESP;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_id    <= alu_src;
            resp_valid <= 1'b1;
            alu_en     <= 1'b0;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            gnt        <= '0;
            ptr        <= alu_src;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_scheduler.sv
// Scoreboard bench for reduce_scheduler with a cycle-level reduce ALU model.
module tb_reduce_scheduler;
  import reduce_pkg::*;

  localparam int BITS    = 8;
  localparam int N       = 64;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = N + 8;
  localparam int IDW     = $clog2(NREQ);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][1:0]      req_sel;
  logic [NREQ-1:0][BITS-1:0] req_len;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            alu_src;
  logic                      alu_set;
  logic                      alu_en;
  logic [1:0]                alu_sel;
  logic [BITS-1:0]           alu_len;
  logic                      alu_done;
  logic [BITS-1:0]           alu_out;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [IDW-1:0]            resp_id;
  logic [BITS-1:0]           resp_data;
  logic                      resp_err;
  logic                      busy;

  reduce_scheduler #(
    .BITS(BITS), .N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_len(req_len),
    .gnt(gnt), .alu_src(alu_src), .alu_set(alu_set), .alu_en(alu_en),
    .alu_sel(alu_sel), .alu_len(alu_len), .alu_done(alu_done), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BITS-1:0] vec [NREQ][N];
  bit alu_hang = 1'b0;

  typedef struct {
    int id;
    int data;
    bit err;
  } exp_t;
  exp_t exp_q[$];
  int   model_ptr = NREQ - 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference reduction over the requester's vector, whole-array arithmetic.
  function automatic int ref_result(input int r);
    int len;
    int acc;
    int s;
    len = int'(req_len[r]);
    if (len > N) len = N;
    case (req_sel[r])
      2'b00: begin
        acc = 0;
        for (int i = 0; i < len; i++) acc += int'(vec[r][i]);
      end
      2'b01: begin
        acc = 0;
        for (int i = 0; i < len; i++) acc |= int'(vec[r][i]);
      end
      2'b10: begin
        acc = 2 ** (BITS - 1) - 1;
        for (int i = 0; i < len; i++) begin
          s = int'($signed(vec[r][i]));
          if (s < acc) acc = s;
        end
      end
      default: begin
        acc = -(2 ** (BITS - 1));
        for (int i = 0; i < len; i++) begin
          s = int'($signed(vec[r][i]));
          if (s > acc) acc = s;
        end
      end
    endcase
    return acc & ((1 << BITS) - 1);
  endfunction

  task automatic push_job(input int r, input bit err);
    exp_t e;
    e.id   = r;
    e.err  = err;
    e.data = err ? 0 : ref_result(r);
    exp_q.push_back(e);
    model_ptr = r;
  endtask

  // Requesters raised together are served cyclically starting after the pointer.
  task automatic push_batch(input logic [NREQ-1:0] mask);
    int start;
    int id;
    start = model_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      id = (start + k) % NREQ;
      if (mask[id]) push_job(id, 1'b0);
    end
  endtask

  // Reduce ALU model: loads on set, consumes one element per enabled cycle.
  initial begin
    bit              s_set, s_en, s_rst;
    logic [1:0]      s_sel, a_sel;
    logic [BITS-1:0] s_len, v;
    logic [IDW-1:0]  s_src, a_src;
    int              a_cnt, a_idx;
    alu_done = 1'b0;
    alu_out  = '0;
    a_cnt = 0; a_idx = 0; a_sel = '0; a_src = '0;
    forever begin
      @(negedge clk);
      s_set = alu_set; s_en = alu_en; s_rst = rst_n;
      s_sel = alu_sel; s_len = alu_len; s_src = alu_src;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        alu_done = 1'b0;
        alu_out  = '0;
        a_cnt    = 0;
      end else if (s_set) begin
        a_cnt    = int'(s_len);
        a_idx    = 0;
        a_sel    = s_sel;
        a_src    = s_src;
        alu_done = 1'b0;
        case (s_sel)
          2'b10:   alu_out = 8'h7F;
          2'b11:   alu_out = 8'h80;
          default: alu_out = 8'h00;
        endcase
      end else if (s_en && !alu_done && !alu_hang) begin
        if (a_cnt == 0) begin
          alu_done = 1'b1;
        end else begin
          v = vec[a_src][a_idx % N];
          case (a_sel)
            2'b00:   alu_out = alu_out + v;
            2'b01:   alu_out = alu_out | v;
            2'b10:   if ($signed(v) < $signed(alu_out)) alu_out = v;
            default: if ($signed(v) > $signed(alu_out)) alu_out = v;
          endcase
          a_idx++;
          a_cnt--;
        end
      end
    end
  end

  // Monitor: every accepted response is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_id", resp_id, -1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_id", resp_id, e.id);
          chk("resp_data", resp_data, e.data);
          chk("resp_err", resp_err, e.err);
          chk("resp_gnt", gnt, 1 << e.id);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  // Drive until n handshakes; hold keeps reqs high until the last one.
  task automatic run_until(input int n, input bit hold, input bit rnd);
    int got;
    int budget;
    got = 0;
    budget = 0;
    while (got < n && budget < 4000) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin
        got++;
        if (!hold) req[resp_id] = 1'b0;
        else if (got == n) req = '0;
      end
      @(posedge clk);
      #1;
      budget++;
      if (rnd) resp_ready = ($urandom_range(0, 3) != 0);
    end
    resp_ready = 1'b1;
    chk("run_budget_ok", longint'(budget < 4000), 1);
  endtask

  // Count cycles from acceptance until resp_valid is seen.
  task automatic wait_resp(input int r, input bit perturb, inout int lat, output int nset);
    nset = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (alu_set) nset++;
      if (perturb && lat == 2) begin
        req_sel[r] = OP_MAX;
        req_len[r] = 8'd1;
      end
    end
  endtask

  int              lat, nset, exp_d;
  logic [NREQ-1:0] mask;

  initial begin
    rst_n      = 1'b0;
    req        = '0;
    req_sel    = '0;
    req_len    = '0;
    resp_ready = 1'b1;
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < N; i++) vec[r][i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_alu_set", alu_set, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_len", alu_len, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round robin with all requests held: order 0,1,2,3,0.
    for (int r = 0; r < NREQ; r++) begin
      req_len[r] = 8'd2;
      req_sel[r] = 2'(r);
      vec[r][0]  = 8'hFD;
      vec[r][1]  = 8'h05;
    end
    for (int k = 0; k < 5; k++) push_job((model_ptr + 1) % NREQ, 1'b0);
    req = '1;
    run_until(5, 1'b1, 1'b0);

    // Single job {1,2,3,4} sum; inputs perturbed mid-job must be ignored.
    req_sel[0] = OP_SUM;
    req_len[0] = 8'd4;
    for (int i = 0; i < 4; i++) vec[0][i] = 8'(i + 1);
    push_job(0, 1'b0);
    req[0] = 1'b1;
    lat = 0;
    wait_resp(0, 1'b1, lat, nset);
    chk("single_latency", lat, 8);
    chk("single_set_pulses", nset, 1);
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("single_idle_busy", busy, 0);

    // Backpressure with req[1] waiting.
    req_sel[0] = OP_MAX;
    req_len[0] = 8'd3;
    for (int i = 0; i < N; i++) vec[0][i] = 8'($urandom);
    exp_d = ref_result(0);
    push_job(0, 1'b0);
    resp_ready = 1'b0;
    req[0] = 1'b1;
    lat = 0;
    wait_resp(0, 1'b0, lat, nset);
    chk("bp_latency", lat, 7);
    req_sel[1] = OP_OR;
    req_len[1] = 8'd5;
    push_job(1, 1'b0);
    req[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, 0);
      chk("bp_data", resp_data, exp_d);
      chk("bp_gnt", gnt, 1);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    req[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_gnt_idle", gnt, 0);
    @(posedge clk);
    #1;
    chk("bp_gnt_next", gnt, 2);
    chk("bp_set_next", alu_set, 1);
    lat = 1;
    wait_resp(1, 1'b0, lat, nset);
    chk("bp_next_latency", lat, 9);
    req[1] = 1'b0;
    @(posedge clk);
    #1;

    // Clamp: len 200 -> 64, requester drops req mid-job.
    req_sel[2] = OP_SUM;
    req_len[2] = 8'd200;
    for (int i = 0; i < N; i++) vec[2][i] = 8'($urandom);
    push_job(2, 1'b0);
    req[2] = 1'b1;
    @(posedge clk);
    #1;
    chk("clamp_alu_len", alu_len, 64);
    req[2] = 1'b0;
    lat = 1;
    wait_resp(2, 1'b0, lat, nset);
    chk("clamp_latency", lat, 68);
    @(posedge clk);
    #1;

    // Zero length: sum -> 0, min -> max-positive identity.
    req_sel[3] = OP_SUM;
    req_len[3] = 8'd0;
    push_job(3, 1'b0);
    req[3] = 1'b1;
    lat = 0;
    wait_resp(3, 1'b0, lat, nset);
    chk("zero_latency", lat, 4);
    req[3] = 1'b0;
    @(posedge clk);
    #1;
    req_sel[1] = OP_MIN;
    req_len[1] = 8'd0;
    push_job(1, 1'b0);
    req[1] = 1'b1;
    lat = 0;
    wait_resp(1, 1'b0, lat, nset);
    chk("zero_min_latency", lat, 4);
    req[1] = 1'b0;
    @(posedge clk);
    #1;

    // Timeout: ALU never completes.
    alu_hang = 1'b1;
    req_sel[1] = OP_SUM;
    req_len[1] = 8'd5;
    push_job(1, 1'b1);
    req[1] = 1'b1;
    lat = 0;
    wait_resp(1, 1'b0, lat, nset);
    chk("timeout_latency", lat, TIMEOUT + 2);
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("timeout_idle_busy", busy, 0);
    alu_hang = 1'b0;

    // Reset in the middle of a len=30 job.
    req_sel[2] = OP_SUM;
    req_len[2] = 8'd30;
    req[2] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_gnt", gnt, 0);
    chk("mrst_alu_src", alu_src, 0);
    chk("mrst_alu_set", alu_set, 0);
    chk("mrst_alu_en", alu_en, 0);
    chk("mrst_alu_sel", alu_sel, 0);
    chk("mrst_alu_len", alu_len, 0);
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_resp_id", resp_id, 0);
    chk("mrst_resp_data", resp_data, 0);
    chk("mrst_resp_err", resp_err, 0);
    chk("mrst_busy", busy, 0);
    rst_n = 1'b1;
    req = '0;
    model_ptr = NREQ - 1;
    repeat (40) @(posedge clk);
    #1;
    mask = 4'b1011;
    for (int r = 0; r < NREQ; r++) begin
      req_sel[r] = 2'($urandom_range(0, 3));
      req_len[r] = 8'($urandom_range(1, 6));
    end
    push_batch(mask);
    req = mask;
    @(posedge clk);
    #1;
    chk("mrst_first_gnt", gnt, 1);
    run_until(3, 1'b0, 1'b0);

    // Randomized batches with random backpressure.
    for (int it = 0; it < 30; it++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        if (mask[r]) begin
          req_sel[r] = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 5))
            0:       req_len[r] = 8'd0;
            1:       req_len[r] = 8'($urandom_range(60, 255));
            default: req_len[r] = 8'($urandom_range(1, 20));
          endcase
          for (int i = 0; i < N; i++) vec[r][i] = 8'($urandom);
        end
      end
      push_batch(mask);
      req = mask;
      run_until($countones(mask), 1'b0, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
